// File: rtl/seven_seg_pkg.sv
// Shared types, glyph table and blanking helper for the seven-segment scanner.
// Segment vectors are active-low {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    typedef logic [1:0] digit_idx_t;
    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    localparam seg_t HEX_TO_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,  // 0 1 2 3
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,  // 4 5 6 7
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,  // 8 9 A b
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110   // C d E F
    };

    // A digit is a leading zero when it and every nibble above it are zero
    // and no DP at or above it is requested; digit 0 always stays lit.
    function automatic logic lz_blank(input logic [15:0] val,
                                      input logic [3:0]  dpm,
                                      input digit_idx_t  idx);
        logic blank;
        blank = 1'b0;
        case (idx)
            2'd3:    blank = (val[15:12] == 4'h0)  && (dpm[3]   == 1'b0);
            2'd2:    blank = (val[15:8]  == 8'h00) && (dpm[3:2] == 2'b00);
            2'd1:    blank = (val[15:4]  == 12'h0) && (dpm[3:1] == 3'b000);
            default: blank = 1'b0;
        endcase
        return blank;
    endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output seg_t       seg_o
);

    assign seg_o = HEX_TO_SEG[nibble_i];

endmodule

// File: rtl/seven_segment_scanner.sv
// Four-digit time-multiplexed seven-segment driver with per-frame snapshot.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_TICKS = 100_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] display_in,
    input  logic [3:0]  decimal_point,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int            PW   = $clog2(DIGIT_TICKS);
    localparam logic [PW-1:0] LAST = PW'(DIGIT_TICKS - 1);

    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    logic [15:0]   val_q, val_d;
    logic [3:0]    dpm_q, dpm_d;
    logic [3:0]    an_q, an_d;
    seg_t          seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          fd_q, fd_d;

    logic          tick;
    logic          wrap;
    logic          snap_load;
    logic          blank;
    logic [3:0]    nibble;
    seg_t          glyph;

    hex_to_seven_seg u_decode (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    // Pins are computed from next-state values so the new frame's digit 0
    // appears in the same cycle as frame_done.
    always_comb begin
        tick      = (presc_q == LAST);
        wrap      = tick && (idx_q == 2'd3);
        snap_load = !enable || wrap;

        presc_d = '0;
        idx_d   = '0;
        if (enable) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            idx_d   = idx_q + digit_idx_t'(tick);
        end

        val_d  = snap_load ? display_in    : val_q;
        dpm_d  = snap_load ? decimal_point : dpm_q;
        nibble = val_d[{idx_d, 2'b00} +: 4];

`ifdef SEVEN_SEG_LZB_EN
        blank = !enable || lz_blank(val_d, dpm_d, idx_d);
`else
        blank = !enable;
`endif

        an_d  = blank ? 4'hF      : ~(4'b0001 << idx_d);
        seg_d = blank ? SEG_BLANK : glyph;
        dp_d  = blank ? 1'b1      : ~dpm_d[idx_d];
        fd_d  = wrap && enable;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            val_q   <= '0;
            dpm_q   <= '0;
            an_q    <= 4'hF;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            val_q   <= val_d;
            dpm_q   <= dpm_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner with a cycle-level reference
// model feeding an expected-output queue; honours SEVEN_SEG_LZB_EN.
module tb_seven_segment_scanner;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] display_in = 16'h0;
    logic [3:0]  decimal_point = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_segment_scanner #(.DIGIT_TICKS(T)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .display_in    (display_in),
        .decimal_point (decimal_point),
        .an            (an),
        .seg           (seg),
        .dp            (dp),
        .frame_done    (frame_done)
    );

    int n_vec = 0;
    int n_err = 0;
    int fd_count = 0;

    // {an, seg, dp, frame_done}
    logic [12:0] exp_q[$];

    int          m_presc;
    int          m_idx;
    logic [15:0] m_val;
    logic [3:0]  m_dp;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Predict the pins after the coming rising edge from the current inputs.
    task automatic model_push();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        logic       tick;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_fd  = 1'b0;
        if (!enable) begin
            m_presc = 0;
            m_idx   = 0;
            m_val   = display_in;
            m_dp    = decimal_point;
        end else begin
            tick    = (m_presc == T - 1);
            e_fd    = tick && (m_idx == 3);
            m_presc = tick ? 0 : m_presc + 1;
            if (tick) m_idx = (m_idx + 1) % 4;
            if (e_fd) begin
                m_val = display_in;
                m_dp  = decimal_point;
            end
            e_an[m_idx] = 1'b0;
            e_seg       = glyph(m_val[4*m_idx +: 4]);
            e_dp        = !m_dp[m_idx];
`ifdef SEVEN_SEG_LZB_EN
            if (m_idx > 0 && (m_val >> (4 * m_idx)) == 16'h0 && (m_dp >> m_idx) == 4'h0) begin
                e_an  = 4'hF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end
`endif
        end
        exp_q.push_back({e_an, e_seg, e_dp, e_fd});
    endtask

    task automatic step();
        logic [12:0] e;
        model_push();
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("an",         32'(an),         32'(e[12:9]));
        check("seg",        32'(seg),        32'(e[8:2]));
        check("dp",         32'(dp),         32'(e[1]));
        check("frame_done", 32'(frame_done), 32'(e[0]));
        if (frame_done) fd_count++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asserted just after an edge so the async path is what clears the pins.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_an",  32'(an),         32'hF);
        check("rst_seg", 32'(seg),        32'h7F);
        check("rst_dp",  32'(dp),         32'h1);
        check("rst_fd",  32'(frame_done), 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_an", 32'(an), 32'hF);
        m_presc = 0;
        m_idx   = 0;
        m_val   = 16'h0;
        m_dp    = 4'h0;
        exp_q.delete();
        reset_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Plain scan of 1234
        enable        = 1'b1;
        display_in    = 16'h1234;
        decimal_point = 4'h0;
        run(8);
        fd_count = 0;
        run(64);
        check("frame_done_rate", 32'(fd_count), 32'd4);

        // Change mid-frame while digit 1 is lit: no tearing
        for (int i = 0; i < 16 && m_idx != 1; i++) step();
        display_in = 16'hABCD;
        run(40);

        // DP on digit 2 only
        decimal_point = 4'b0100;
        run(24);

        // Disable mid-scan, re-enable
        for (int i = 0; i < 16 && m_idx != 2; i++) step();
        enable = 1'b0;
        step();
        check("dis_an", 32'(an), 32'hF);
        for (int i = 0; i < 4; i++) begin
            display_in    = 16'($urandom_range(0, 16'hFFFF));
            decimal_point = 4'($urandom_range(0, 15));
            step();
        end
        enable = 1'b1;
        step();
        check("reen_an",  32'(an),  32'hE);
        check("reen_seg", 32'(seg), 32'(glyph(display_in[3:0])));
        run(20);

        // Leading-zero candidates (blanked only when the macro is defined)
        display_in    = 16'h0007;
        decimal_point = 4'h0;
        run(36);
        display_in    = 16'h0012;
        decimal_point = 4'b0100;
        run(36);

        // Mid-frame reset then restart
        run(5);
        do_reset();
        enable        = 1'b1;
        display_in    = 16'h5E90;
        decimal_point = 4'b1001;
        run(24);

        // Random traffic
        for (int r = 0; r < 20; r++) begin
            display_in    = 16'($urandom_range(0, 16'hFFFF));
            decimal_point = 4'($urandom_range(0, 15));
            enable        = ($urandom_range(0, 7) != 0);
            run($urandom_range(1, 20));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
